cache_fill_ctrl: RTL and testbench

Miss-handling front end for the 2-way, 16-set, 4-byte-line cache. Accepts single-byte read requests from the core, looks them up in the cache through its enableread/enablewrite pin interface, and on a miss fetches the 4-byte line from main memory, writes it into the cache byte by byte, and returns the requested byte. Sits directly upstream of the cache, between the core and both the cache and the memory bus.

---
 rtl/cache_fill_ctrl_if.sv | 48 ++++
 rtl/cache_fill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of the core request/response, cache pin and memory-bus signals
// used by cache_fill_ctrl; master is the controller side, slave its environment.
interface cache_fill_ctrl_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;

    logic        cache_enableread;
    logic        cache_enablewrite;
    logic [15:0] cache_address;
    logic [7:0]  cache_datain;
    logic [1:0]  cache_writebyte;
    logic [7:0]  cache_dataout;
    logic        cache_hitmiss;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;

    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport master (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data,
        output cache_enableread, cache_enablewrite, cache_address,
        output cache_datain, cache_writebyte,
        input  cache_dataout, cache_hitmiss,
        output mem_req, mem_addr,
        input  mem_ack, mem_rvalid, mem_rdata,
        output hit_count, miss_count
    );

    modport slave (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data,
        input  cache_enableread, cache_enablewrite, cache_address,
        input  cache_datain, cache_writebyte,
        output cache_dataout, cache_hitmiss,
        input  mem_req, mem_addr,
        output mem_ack, mem_rvalid, mem_rdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss-handling front end for the 2-way/16-set/4-byte-line cache: lookup, line fetch, byte-wise fill, response.
// Optional hit/miss statistics counters are built when CACHE_FILL_STATS_EN is defined.
module cache_fill_ctrl (
    input logic               clk,
    input logic               reset,
    cache_fill_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        RD_WAIT,
        CHECK,
        MEM_REQ,
        FILL,
        WR_EN,
        WR_SEL,
        WR_BYTE,
        RESP
    } state_e;

    state_e          state_q;
    logic [15:0]     addr_q;
    logic [3:0][7:0] fill_buf_q;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_inc;

    logic            rd_en_q;
    logic            wr_en_q;
    logic            mem_req_q;
    logic [15:0]     mem_addr_q;
    logic            resp_valid_q;
    logic [7:0]      resp_data_q;
    logic [1:0]      wbyte_q;
    logic [7:0]      datain_q;

    assign cnt_inc = cnt_q + 2'd1;

    // cnt_q counts fill bytes in FILL and is reused as the write index k in WR_BYTE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            fill_buf_q   <= '0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            wbyte_q      <= '0;
            datain_q     <= '0;
        end else begin
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        rd_en_q <= 1'b1;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP:  state_q <= RD_WAIT;
                RD_WAIT: state_q <= CHECK;
                CHECK: begin
                    if (bus.cache_hitmiss) begin
                        resp_data_q  <= bus.cache_dataout;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {addr_q[15:2], 2'b00};
                        state_q    <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_ack) begin
                        mem_req_q  <= 1'b0;
                        mem_addr_q <= '0;
                        cnt_q      <= '0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_rvalid) begin
                        fill_buf_q[cnt_q] <= bus.mem_rdata;
                        cnt_q             <= cnt_inc;
                        if (cnt_q == 2'd3) begin
                            wr_en_q <= 1'b1;
                            state_q <= WR_EN;
                        end
                    end
                end
                WR_EN: state_q <= WR_SEL;
                WR_SEL: begin
                    cnt_q    <= '0;
                    wbyte_q  <= '0;
                    datain_q <= fill_buf_q[0];
                    state_q  <= WR_BYTE;
                end
                WR_BYTE: begin
                    if (cnt_q == 2'd3) begin
                        wbyte_q      <= '0;
                        datain_q     <= '0;
                        resp_data_q  <= fill_buf_q[addr_q[1:0]];
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q    <= cnt_inc;
                        wbyte_q  <= cnt_inc;
                        datain_q <= fill_buf_q[cnt_inc];
                    end
                end
                RESP: begin
                    resp_data_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is combinational so it is low while reset is held and high the first cycle after
    assign bus.req_ready         = (state_q == IDLE) && !reset;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_data         = resp_data_q;
    assign bus.cache_enableread  = rd_en_q;
    assign bus.cache_enablewrite = wr_en_q;
    assign bus.cache_address     = addr_q;
    assign bus.cache_datain      = datain_q;
    assign bus.cache_writebyte   = wbyte_q;
    assign bus.mem_req           = mem_req_q;
    assign bus.mem_addr          = mem_addr_q;

`ifdef CACHE_FILL_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == CHECK) begin
            if (bus.cache_hitmiss) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    assign bus.hit_count  = '0;
    assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: behavioural 2-way LRU cache and memory responders,
// a directed vector table, hand-written reset/stats sequences and a randomized phase.
module tb_cache_fill_ctrl;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cache_fill_ctrl_if bus ();

    cache_fill_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

`ifdef CACHE_FILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [65536];

    // behavioural cache: 16 sets x 2 ways, LRU, 4-byte lines
    logic [9:0]      c_tag [16][2];
    bit              c_vld [16][2];
    logic [3:0][7:0] c_dat [16][2];
    bit              c_lru [16];

    logic [15:0] cur_addr = '0;
    int lookup_cyc = -1;
    int last_byte_cyc = -1;
    int ack_dly = 0;
    int gap_mode = 0;
    bit spur_en = 1'b0;
    int nb_sent = 0;
    int n_hit = 0;
    int n_miss = 0;

    typedef struct {
        string       name;
        logic [15:0] addr;
        bit          exp_hit;
        logic [7:0]  exp_data;
        int          dly;
        int          gap;
    } vec_t;
    vec_t vq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5C;
    endfunction

    function automatic bit peek_hit(input logic [15:0] a);
        logic [3:0] ix;
        ix = a[5:2];
        return (c_vld[ix][0] && c_tag[ix][0] == a[15:6]) || (c_vld[ix][1] && c_tag[ix][1] == a[15:6]);
    endfunction

    task automatic cache_clear();
        for (int s = 0; s < 16; s++) begin
            c_vld[s[3:0]][0] = 1'b0;
            c_vld[s[3:0]][1] = 1'b0;
            c_lru[s[3:0]]    = 1'b0;
        end
    endtask

    task automatic add_vec(input string n, input logic [15:0] a, input bit h, input logic [7:0] d,
                           input int dl, input int g);
        vec_t v;
        v.name = n; v.addr = a; v.exp_hit = h; v.exp_data = d; v.dly = dl; v.gap = g;
        vq.push_back(v);
    endtask

    // Cache and memory responder: drives inputs and checks strobe timing every cycle
    initial begin : responder
        logic [3:0]      ridx;
        bit              rhit;
        bit              w;
        logic [7:0]      rdata;
        logic [3:0][7:0] wline;
        bit              wok;
        int rd_stage = 0;
        int wr_stage = 0;
        int wk = 0;
        int mstate = 0;
        int dly = 0;
        int since = 0;
        int offs [$];
        rhit = 1'b0;
        rdata = '0;
        wline = '0;
        wok = 1'b0;
        ridx = '0;
        bus.cache_hitmiss = 1'b0;
        bus.cache_dataout = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = '0;
            if (rst) begin
                cache_clear();
                rd_stage = 0;
                wr_stage = 0;
                mstate = 0;
                bus.cache_hitmiss = 1'b0;
                bus.cache_dataout = '0;
            end else begin
                chk("rd_strobe", bus.cache_enableread, cyc == lookup_cyc);
                chk("wr_strobe", bus.cache_enablewrite, last_byte_cyc >= 0 && cyc == last_byte_cyc + 1);

                if (rd_stage == 0 && bus.cache_enableread) begin
                    ridx = bus.cache_address[5:2];
                    rhit = 1'b0;
                    rdata = 8'($urandom);
                    for (int wi = 0; wi < 2; wi++) begin
                        w = wi[0];
                        if (c_vld[ridx][w] && c_tag[ridx][w] == bus.cache_address[15:6]) begin
                            rhit = 1'b1;
                            rdata = c_dat[ridx][w][bus.cache_address[1:0]];
                            c_lru[ridx] = ~w;
                        end
                    end
                    rd_stage = 1;
                end else if (rd_stage != 0) begin
                    rd_stage++;
                end
                // only the CHECK cycle carries the real lookup result
                if (rd_stage == 3) begin
                    bus.cache_hitmiss = rhit;
                    bus.cache_dataout = rdata;
                end else begin
                    bus.cache_hitmiss = ~rhit;
                    bus.cache_dataout = ~rdata;
                end
                if (rd_stage == 4) rd_stage = 0;

                if (wr_stage != 2)
                    chk("wr_pins_idle", {bus.cache_writebyte, bus.cache_datain}, 0);
                if (wr_stage == 2) begin
                    if (bus.cache_writebyte !== wk[1:0] ||
                        bus.cache_datain !== mem[{cur_addr[15:2], wk[1:0]}]) wok = 1'b0;
                    wline[wk[1:0]] = bus.cache_datain;
                    wk++;
                    if (wk == 4) begin
                        chk("fill_write_seq", wok, 1);
                        ridx = bus.cache_address[5:2];
                        if (!c_vld[ridx][0]) w = 1'b0;
                        else if (!c_vld[ridx][1]) w = 1'b1;
                        else w = c_lru[ridx];
                        c_vld[ridx][w] = 1'b1;
                        c_tag[ridx][w] = bus.cache_address[15:6];
                        c_dat[ridx][w] = wline;
                        c_lru[ridx] = ~w;
                        wr_stage = 0;
                    end
                end else if (wr_stage == 1) begin
                    wr_stage = 2;
                    wk = 0;
                    wok = 1'b1;
                end else if (bus.cache_enablewrite) begin
                    wr_stage = 1;
                end

                if (bus.mem_req)
                    chk("mem_addr", bus.mem_addr, {cur_addr[15:2], 2'b00});
                if (mstate == 2) begin
                    chk("mem_req_after_ack", bus.mem_req, 0);
                    since++;
                    if (nb_sent < 4 && since == offs[nb_sent]) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = mem[{cur_addr[15:2], nb_sent[1:0]}];
                        nb_sent++;
                        if (nb_sent == 4) begin
                            last_byte_cyc = cyc;
                            mstate = 0;
                        end
                    end
                end else begin
                    if (mstate == 0 && bus.mem_req) begin
                        dly = ack_dly;
                        mstate = 1;
                    end
                    if (mstate == 1) begin
                        if (dly == 0) begin
                            bus.mem_ack = 1'b1;
                            mstate = 2;
                            since = 0;
                            nb_sent = 0;
                            offs.delete();
                            case (gap_mode)
                                1: begin offs.push_back(1); offs.push_back(4); offs.push_back(5); offs.push_back(9); end
                                2: begin offs.push_back(1); offs.push_back(2); offs.push_back(60); offs.push_back(61); end
                                3: begin
                                    offs.push_back(1 + $urandom_range(0, 2));
                                    for (int k = 1; k < 4; k++) offs.push_back(offs[k-1] + 1 + $urandom_range(0, 3));
                                end
                                default: begin offs.push_back(1); offs.push_back(2); offs.push_back(3); offs.push_back(4); end
                            endcase
                        end else begin
                            dly--;
                        end
                    end
                    // stray read data outside the fill window must be ignored
                    if (spur_en && !bus.mem_ack && $urandom_range(0, 2) == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = 8'($urandom);
                    end
                end
            end
        end
    end

    task automatic do_read(input string nm, input logic [15:0] a, input bit exp_hit, input logic [7:0] exp_d);
        int t;
        int a_cyc;
        int r_cyc;
        bit seen_req;
        bit addr_ok;
        bit ready_low;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_ready"}, bus.req_ready, 1);
        cur_addr = a;
        a_cyc = cyc;
        lookup_cyc = cyc + 1;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr = 16'($urandom);
        seen_req = 1'b0;
        addr_ok = 1'b1;
        ready_low = 1'b1;
        r_cyc = -1;
        t = 0;
        while (r_cyc < 0 && t < 400) begin
            if (bus.mem_req) seen_req = 1'b1;
            if (bus.cache_address !== a) addr_ok = 1'b0;
            if (bus.req_ready !== 1'b0) ready_low = 1'b0;
            if (bus.resp_valid === 1'b1) r_cyc = cyc;
            else begin
                @(negedge clk);
                t++;
            end
        end
        chk({nm, "_resp_seen"}, r_cyc >= 0, 1);
        chk({nm, "_resp_data"}, bus.resp_data, exp_d);
        chk({nm, "_mem_req"}, seen_req, !exp_hit);
        chk({nm, "_latency"}, r_cyc, exp_hit ? a_cyc + 4 : last_byte_cyc + 7);
        chk({nm, "_addr_stable"}, addr_ok, 1);
        chk({nm, "_busy_not_ready"}, ready_low, 1);
        @(negedge clk);
        chk({nm, "_resp_pulse"}, bus.resp_valid, 0);
        chk({nm, "_ready_after"}, bus.req_ready, 1);
        if (exp_hit) n_hit++;
        else n_miss++;
    endtask

    initial begin : main
        int t;
        logic [9:0]  tg;
        logic [3:0]  ix;
        logic [1:0]  by;
        logic [15:0] ra;
        for (int i = 0; i < 65536; i++) mem[i] = mem_val(i[15:0]);
        mem[16'h1234] = 8'hA0;
        mem[16'h1235] = 8'hA1;
        mem[16'h1236] = 8'hA2;
        mem[16'h1237] = 8'hA3;
        cache_clear();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_ready_low", bus.req_ready, 0);
            chk("reset_outputs", {bus.resp_valid, bus.cache_enableread, bus.cache_enablewrite, bus.mem_req,
                                  bus.resp_data, bus.cache_writebyte, bus.cache_datain}, 0);
            chk("reset_addrs", {bus.cache_address, bus.mem_addr}, 0);
            chk("reset_counts", {bus.hit_count, bus.miss_count}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1);

        add_vec("cold_miss",   16'h1234, 1'b0, 8'hA0, 0, 0);
        add_vec("warm_hit",    16'h1236, 1'b1, 8'hA2, 0, 0);
        add_vec("gap_fill",    16'h2001, 1'b0, mem_val(16'h2001), 0, 1);
        add_vec("slow_ack",    16'h2402, 1'b0, mem_val(16'h2402), 3, 0);
        add_vec("lru_t0",      16'h000D, 1'b0, mem_val(16'h000D), 0, 0);
        add_vec("lru_t1",      16'h004D, 1'b0, mem_val(16'h004D), 0, 0);
        add_vec("lru_t2",      16'h008D, 1'b0, mem_val(16'h008D), 0, 0);
        add_vec("lru_t1_hit",  16'h004D, 1'b1, mem_val(16'h004D), 0, 0);
        add_vec("lru_t0_miss", 16'h000D, 1'b0, mem_val(16'h000D), 0, 0);
        add_vec("lru_t1_hit2", 16'h004E, 1'b1, mem_val(16'h004E), 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            ack_dly = vq[i].dly;
            gap_mode = vq[i].gap;
            do_read(vq[i].name, vq[i].addr, vq[i].exp_hit, vq[i].exp_data);
        end

        // reset in the middle of a fill after two bytes
        ack_dly = 0;
        gap_mode = 2;
        nb_sent = 0;
        cur_addr = 16'h3001;
        lookup_cyc = cyc + 1;
        bus.req_valid = 1'b1;
        bus.req_addr = 16'h3001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        t = 0;
        while (nb_sent < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_two_bytes_sent", nb_sent >= 2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", bus.req_ready, 0);
        chk("rst_strobes", {bus.mem_req, bus.cache_enableread, bus.cache_enablewrite, bus.resp_valid}, 0);
        rst = 1'b0;
        n_hit = 0;
        n_miss = 0;
        lookup_cyc = -1;
        repeat (12) begin
            @(negedge clk);
            chk("rst_no_write", bus.cache_enablewrite, 0);
            chk("rst_no_resp", bus.resp_valid, 0);
            chk("rst_ready_high", bus.req_ready, 1);
        end

        gap_mode = 0;
        do_read("stat_miss", 16'h5555, 1'b0, mem[16'h5555]);
        do_read("stat_hit0", 16'h5554, 1'b1, mem[16'h5554]);
        do_read("stat_hit1", 16'h5556, 1'b1, mem[16'h5556]);
        do_read("stat_hit2", 16'h5557, 1'b1, mem[16'h5557]);
        chk("stats_hit3", bus.hit_count, STATS ? 3 : 0);
        chk("stats_miss1", bus.miss_count, STATS ? 1 : 0);

        gap_mode = 3;
        spur_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            ack_dly = $urandom_range(0, 3);
            tg = 10'($urandom_range(0, 3));
            ix = 4'($urandom_range(0, 1));
            by = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {tg, ix, by};
            do_read("rand", ra, peek_hit(ra), mem[ra]);
        end
        chk("final_hit_count", bus.hit_count, STATS ? n_hit : 0);
        chk("final_miss_count", bus.miss_count, STATS ? n_miss : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
